// File: rtl/fetch_pkg.sv
// Shared ISA constants and front-end types for the fetch stage.
package fetch_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OP_W    = 5;

    localparam logic [OP_W-1:0]    OP_HALT   = 5'b00000;
    localparam logic [OP_W-1:0]    OP_NOP    = 5'b00001;
    localparam logic [INSTR_W-1:0] NOP_INSTR = {OP_NOP, 11'h000};

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fe_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OP_W] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_pipe_reg.sv
// Generic pipeline register: synchronous reset to RESET_VAL, load when enabled.
module fetch_pipe_reg #(
    parameter int unsigned W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= RESET_VAL;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch.sv
// Instruction-fetch stage with IF/ID register; handles stall, redirect and HALT freeze.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned        PC_W      = 16,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_err,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc_plus2,
    output logic               if_id_valid,
    output logic               halted,
    output logic               err
);

    localparam int unsigned IFID_W = INSTR_W + PC_W + 1;
    localparam logic [IFID_W-1:0] IFID_BUBBLE = {NOP_INSTR, PC_W'(0), 1'b0};

    fe_state_e         r_state;
    fe_state_e         w_state_nxt;
    logic              r_err;
    logic              w_err_nxt;

    logic [PC_W-1:0]   w_pc;
    logic [PC_W-1:0]   w_pc_plus2;
    logic              w_pc_en;
    logic [PC_W-1:0]   w_pc_d;
    logic              w_ifid_en;
    logic [IFID_W-1:0] w_ifid_d;
    logic [IFID_W-1:0] w_ifid_q;

    assign w_pc_plus2 = w_pc + PC_W'(2);

    fetch_pipe_reg #(
        .W         (PC_W),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_pc_en),
        .i_d  (w_pc_d),
        .o_q  (w_pc)
    );

    fetch_pipe_reg #(
        .W         (IFID_W),
        .RESET_VAL (IFID_BUBBLE)
    ) u_if_id_reg (
        .clk  (clk),
        .rst  (rst),
        .i_en (w_ifid_en),
        .i_d  (w_ifid_d),
        .o_q  (w_ifid_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Priority: redirect (flush beats stall) > stall > halted > advance.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_en     = 1'b0;
        w_pc_d      = w_pc;
        w_ifid_en   = 1'b0;
        w_ifid_d    = IFID_BUBBLE;
        w_err_nxt   = r_err
                    | (imem_err & ~stall & (r_state == ST_RUN))
                    | (redirect & redirect_pc[0]);

        if (redirect) begin
            w_pc_en     = 1'b1;
            w_pc_d      = {redirect_pc[PC_W-1:1], 1'b0};
            w_ifid_en   = 1'b1;
            w_state_nxt = ST_RUN;
        end else if (stall) begin
            w_pc_en     = 1'b0;
        end else if (r_state == ST_HALTED) begin
            w_ifid_en   = 1'b1;
        end else begin
            w_ifid_en   = 1'b1;
            w_ifid_d    = {imem_rdata, w_pc_plus2, 1'b1};
            if (is_halt(imem_rdata)) begin
                w_state_nxt = ST_HALTED;
            end else begin
                w_pc_en = 1'b1;
                w_pc_d  = w_pc_plus2;
            end
        end
    end

    assign imem_addr      = w_pc;
    assign if_id_instr    = w_ifid_q[IFID_W-1 -: INSTR_W];
    assign if_id_pc_plus2 = w_ifid_q[PC_W:1];
    assign if_id_valid    = w_ifid_q[0];
    assign halted         = (r_state == ST_HALTED);
    assign err            = r_err;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: expected IF/ID and front-end state queued per cycle, checked after each edge.
module tb_fetch;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_err;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;
    logic        err;

    typedef struct {
        string       tag;
        logic [15:0] instr;
        logic [15:0] pc2;
        logic        valid;
        logic [15:0] addr;
        logic        halted;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mem [0:32767];
    int          errors = 0;
    int          checks = 0;

    fetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_err       (imem_err),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus2 (if_id_pc_plus2),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .err            (err)
    );

    assign imem_rdata = mem[imem_addr[15:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Background memory image: non-HALT opcode 01010 tagged with the word index.
    function automatic logic [15:0] bg(input logic [15:0] addr);
        return {5'b01010, addr[11:1]};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Queue the expected post-edge state, clock once, then compare.
    task automatic step(input string tag, input logic [15:0] instr, input logic [15:0] pc2,
                        input logic valid, input logic [15:0] addr, input logic hlt, input logic e);
        exp_t x;
        x.tag = tag; x.instr = instr; x.pc2 = pc2; x.valid = valid;
        x.addr = addr; x.halted = hlt; x.err = e;
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({x.tag, ".instr"},  if_id_instr,           x.instr);
        chk({x.tag, ".pc2"},    if_id_pc_plus2,        x.pc2);
        chk({x.tag, ".valid"},  16'(if_id_valid),      16'(x.valid));
        chk({x.tag, ".addr"},   imem_addr,             x.addr);
        chk({x.tag, ".halted"}, 16'(halted),           16'(x.halted));
        chk({x.tag, ".err"},    16'(err),              16'(x.err));
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = bg(16'(i * 2));
        mem[16'h0000 >> 1] = 16'h4101;
        mem[16'h0010 >> 1] = 16'h0000;

        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_err = 1'b0;

        // Reset and first fetch
        step("rst0", 16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        step("rst1", 16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        step("f0", 16'h4101, 16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0);
        step("f2", bg(16'h0002), 16'h0004, 1'b1, 16'h0004, 1'b0, 1'b0);

        // Stall three cycles at 0x0004; memory error while stalled is ignored
        stall = 1'b1;
        step("st0", bg(16'h0002), 16'h0004, 1'b1, 16'h0004, 1'b0, 1'b0);
        imem_err = 1'b1;
        step("st1", bg(16'h0002), 16'h0004, 1'b1, 16'h0004, 1'b0, 1'b0);
        imem_err = 1'b0;
        step("st2", bg(16'h0002), 16'h0004, 1'b1, 16'h0004, 1'b0, 1'b0);
        stall = 1'b0;
        step("f4", bg(16'h0004), 16'h0006, 1'b1, 16'h0006, 1'b0, 1'b0);

        // Redirect beats stall
        stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        step("rdst", 16'h0800, 16'h0000, 1'b0, 16'h0040, 1'b0, 1'b0);
        stall = 1'b0; redirect = 1'b0;
        step("f40", bg(16'h0040), 16'h0042, 1'b1, 16'h0042, 1'b0, 1'b0);

        // HALT at 0x0010 freezes the front end until redirected
        redirect = 1'b1; redirect_pc = 16'h0010;
        step("rd10", 16'h0800, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b0);
        redirect = 1'b0;
        step("halt", 16'h0000, 16'h0012, 1'b1, 16'h0010, 1'b1, 1'b0);
        step("hb0", 16'h0800, 16'h0000, 1'b0, 16'h0010, 1'b1, 1'b0);
        imem_err = 1'b1;
        step("hb1", 16'h0800, 16'h0000, 1'b0, 16'h0010, 1'b1, 1'b0);
        imem_err = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0020;
        step("rd20", 16'h0800, 16'h0000, 1'b0, 16'h0020, 1'b0, 1'b0);
        redirect = 1'b0;
        step("f20", bg(16'h0020), 16'h0022, 1'b1, 16'h0022, 1'b0, 1'b0);

        // Odd redirect target: aligned fetch, sticky err until reset
        redirect = 1'b1; redirect_pc = 16'h0033;
        step("rd33", 16'h0800, 16'h0000, 1'b0, 16'h0032, 1'b0, 1'b1);
        redirect = 1'b0;
        step("f32", bg(16'h0032), 16'h0034, 1'b1, 16'h0034, 1'b0, 1'b1);
        step("f34", bg(16'h0034), 16'h0036, 1'b1, 16'h0036, 1'b0, 1'b1);
        rst = 1'b1;
        step("rstE", 16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;

        // Memory error on an advancing fetch sets err without blocking fetch
        imem_err = 1'b1;
        step("ferr", 16'h4101, 16'h0002, 1'b1, 16'h0002, 1'b0, 1'b1);
        imem_err = 1'b0;
        rst = 1'b1;
        step("rstF", 16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;

        // PC wrap at the top of the address space
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step("rdFE", 16'h0800, 16'h0000, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        redirect = 1'b0;
        step("wrap", bg(16'hFFFE), 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b0);
        step("w0", 16'h4101, 16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0);

        // Reset in the middle of a stall
        stall = 1'b1;
        step("st3", 16'h4101, 16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0);
        rst = 1'b1;
        step("rstS", 16'h0800, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        rst = 1'b0; stall = 1'b0;
        step("post", 16'h4101, 16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
